// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM: state encoding,
// opcodes and datapath select codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALRADR  = 4'd10,
      S_JAL      = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_immdec.sv
// Immediate-format select, decoded combinationally from the opcode.
module mc_immdec
   import mc_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] immsrc
);

   always_comb begin
      immsrc = IMM_I;
      case (op)
         OP_STORE:  immsrc = IMM_S;
         OP_BRANCH: immsrc = IMM_B;
         OP_JAL:    immsrc = IMM_J;
         default:   immsrc = IMM_I;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback over a
// shared-ALU, unified-memory datapath, stalling on the memory ready handshake.
module mc_controller
   import mc_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   state_t state, state_next;

   mc_immdec u_immdec (
      .op     (op),
      .immsrc (ImmSrc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= RESET_STATE;
         illegal_op <= 1'b0;
      end else begin
         state <= state_next;
         if (state_next == S_ILLEGAL) illegal_op <= 1'b1;
      end
   end

   assign state_dbg = state;

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCUpdate   = 1'b0;
      Branch     = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUOp      = ALU_ADD;
      ResultSrc  = RES_ALUOUT;
      case (state)
         S_FETCH: begin
            mem_req   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            IRWrite   = mem_ready;
            PCUpdate  = mem_ready;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_R:              state_next = S_EXECR;
               OP_I:              state_next = S_EXECI;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALRADR;
               default:           state_next = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_DATA;
            RegWrite   = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req  = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_next = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            ALUOp      = ALU_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALU_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            ALUOp      = ALU_SUB;
            Branch     = 1'b1;
            state_next = S_FETCH;
         end
         S_JALRADR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            state_next = S_JAL;
         end
         S_JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            PCUpdate   = 1'b1;
            state_next = S_ALUWB;
         end
         S_ILLEGAL: state_next = S_ILLEGAL;
         default:   state_next = S_FETCH;
      endcase
      // A reset cycle must never issue a write or memory access, even mid-instruction.
      if (!reset_n) begin
         mem_req  = 1'b0;
         IRWrite  = 1'b0;
         PCUpdate = 1'b0;
         Branch   = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction state paths expanded
// with random memory stalls, checked cycle by cycle against a table of outputs.
module tb_mc_controller;
   import mc_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic       mem_ready = 1'b0;
   logic       mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc;
   logic       illegal_op;
   logic [3:0] state_dbg;

   int tests = 0;
   int fails = 0;

   mc_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCUpdate   (PCUpdate),
      .Branch     (Branch),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .ResultSrc  (ResultSrc),
      .ImmSrc     (ImmSrc),
      .illegal_op (illegal_op),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected {mem_req,AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,A,B,ALUOp,Result,illegal}
   function automatic logic [15:0] exp_ctrl(state_t s, logic rdy);
      logic req, adr, irw, pcu, br, rw, mw, ill;
      logic [1:0] a, b, alu, res;
      {req, adr, irw, pcu, br, rw, mw, ill} = 8'd0;
      a = 2'b00; b = 2'b00; alu = 2'b00; res = 2'b00;
      case (s)
         S_FETCH:    begin req = 1; b = 2'b10; res = 2'b10; irw = rdy; pcu = rdy; end
         S_DECODE:   begin a = 2'b01; b = 2'b01; end
         S_MEMADR:   begin a = 2'b10; b = 2'b01; end
         S_MEMREAD:  begin req = 1; adr = 1; end
         S_MEMWB:    begin res = 2'b01; rw = 1; end
         S_MEMWRITE: begin req = 1; adr = 1; mw = 1; end
         S_EXECR:    begin a = 2'b10; alu = 2'b10; end
         S_EXECI:    begin a = 2'b10; b = 2'b01; alu = 2'b10; end
         S_ALUWB:    rw = 1;
         S_BRANCH:   begin a = 2'b10; alu = 2'b01; br = 1; end
         S_JALRADR:  begin a = 2'b10; b = 2'b01; end
         S_JAL:      begin a = 2'b01; b = 2'b10; pcu = 1; end
         S_ILLEGAL:  ill = 1;
         default:    ;
      endcase
      return {req, adr, irw, pcu, br, rw, mw, a, b, alu, res, ill};
   endfunction

   function automatic logic [1:0] exp_imm(logic [6:0] o);
      if (o == OP_STORE) return 2'b01;
      if (o == OP_BRANCH) return 2'b10;
      if (o == OP_JAL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [15:0] obs_ctrl();
      return {mem_req, AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
              ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_op};
   endfunction

   function automatic logic [5:0] obs_strobes();
      return {mem_req, IRWrite, PCUpdate, Branch, RegWrite, MemWrite};
   endfunction

   // stall < 0 picks a random 0..3 wait count for each memory access
   task automatic run_instr(input logic [6:0] opc, input int stall);
      state_t path[$];
      state_t seq[$];
      logic   rdys[$];
      int     k;
      path.push_back(S_FETCH);
      path.push_back(S_DECODE);
      case (opc)
         OP_LOAD:   begin path.push_back(S_MEMADR); path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
         OP_STORE:  begin path.push_back(S_MEMADR); path.push_back(S_MEMWRITE); end
         OP_R:      begin path.push_back(S_EXECR); path.push_back(S_ALUWB); end
         OP_I:      begin path.push_back(S_EXECI); path.push_back(S_ALUWB); end
         OP_BRANCH: path.push_back(S_BRANCH);
         OP_JAL:    begin path.push_back(S_JAL); path.push_back(S_ALUWB); end
         OP_JALR:   begin path.push_back(S_JALRADR); path.push_back(S_JAL); path.push_back(S_ALUWB); end
         default:   repeat (6) path.push_back(S_ILLEGAL);
      endcase
      foreach (path[i]) begin
         if (path[i] == S_FETCH || path[i] == S_MEMREAD || path[i] == S_MEMWRITE) begin
            k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            repeat (k) begin seq.push_back(path[i]); rdys.push_back(1'b0); end
            seq.push_back(path[i]);
            rdys.push_back(1'b1);
         end else begin
            seq.push_back(path[i]);
            rdys.push_back(1'($urandom_range(0, 1)));
         end
      end
      op = opc;
      foreach (seq[i]) begin
         mem_ready = rdys[i];
         #1;
         check("state", 32'(state_dbg), 32'(seq[i]));
         check("ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(seq[i], rdys[i])));
         check("immsrc", 32'(ImmSrc), 32'(exp_imm(opc)));
         @(posedge clk);
         #1;
      end
   endtask

   logic [6:0] ops [7];

   initial begin
      ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR};

      // power-on reset
      @(posedge clk); #1;
      check("rst_strobes", 32'(obs_strobes()), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      check("rst_state", 32'(state_dbg), 32'(S_FETCH));
      check("rst_illegal", 32'(illegal_op), 32'd0);

      run_instr(OP_LOAD, 0);
      run_instr(OP_STORE, 3);
      run_instr(OP_R, 2);
      run_instr(OP_JALR, 0);
      run_instr(OP_BRANCH, 1);

      // reset held two cycles while waiting in S_MEMREAD
      op = OP_LOAD;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      check("memread_state", 32'(state_dbg), 32'(S_MEMREAD));
      reset_n = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("midrst_strobes", 32'(obs_strobes()), 32'd0);
         @(posedge clk); #1;
      end
      reset_n = 1'b1;
      #1;
      check("midrst_state", 32'(state_dbg), 32'(S_FETCH));
      run_instr(OP_I, 0);

      // illegal opcode trap, sticky until reset
      run_instr(7'b0000000, 0);
      check("trap_sticky", 32'(illegal_op), 32'd1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      check("trap_clear", 32'(illegal_op), 32'd0);
      check("trap_state", 32'(state_dbg), 32'(S_FETCH));

      repeat (40) run_instr(ops[$urandom_range(0, 6)], -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
